// File: rtl/gal_ctrl_seq_pkg.sv
// Shared types and configuration helpers for the GAL counter control stage.
package gal_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CLR  = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Bit positions of the front-panel inputs in the debounced vectors.
  localparam int IDX_LOAD  = 0;
  localparam int IDX_CLEAR = 1;
  localparam int IDX_RUN   = 2;
  localparam int IDX_DATA  = 3;

  // The debounce counter must be able to reach DEBOUNCE_CYCLES-1.
  function automatic bit cnt_w_fits(input int cnt_w, input int cycles);
    return ((1 << cnt_w) > cycles) && (cycles >= 1);
  endfunction

endpackage

// File: rtl/gal_ctrl_seq_if.sv
// Front-panel inputs and counter-side outputs of the control stage.
interface gal_ctrl_seq_if;
  logic LoadBtn;
  logic ClearBtn;
  logic RunSw;
  logic DataSw;
  logic Set;
  logic Clear;
  logic D;
  logic OE;

  modport master (output LoadBtn, ClearBtn, RunSw, DataSw,
                  input  Set, Clear, D, OE);
  modport slave  (input  LoadBtn, ClearBtn, RunSw, DataSw,
                  output Set, Clear, D, OE);
endinterface

// File: rtl/gal_ctrl_seq_debounce.sv
// One front-panel input: 2-flop synchronizer, counting debounce filter and
// rising-edge detect on the filtered level.
module gal_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic raw_i,
  output logic filt_o,
  output logic rise_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic             filt_dly_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      filt_dly_q <= filt_q;
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_q <= ~filt_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign filt_o = filt_q;
  assign rise_o = filt_q & ~filt_dly_q;

endmodule

// File: rtl/gal_ctrl_seq.sv
// Control sequencer: debounces the panel inputs and issues Set/Clear strobes,
// load data and the active-low count enable to the GAL counter.
module gal_ctrl_seq
  import gal_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 3
) (
  input  logic           Clock,
  input  logic           Reset_n,
  gal_ctrl_seq_if.slave  bus
);

  if (!cnt_w_fits(CNT_W, DEBOUNCE_CYCLES)) begin : g_bad_cfg
    $error("gal_ctrl_seq: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  logic [3:0] raw;
  logic [3:0] filt;
  logic [3:0] rise;
  logic       unused_rise;

  assign raw = {bus.DataSw, bus.RunSw, bus.ClearBtn, bus.LoadBtn};

  for (genvar gi = 0; gi < 4; gi++) begin : g_deb
    gal_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .raw_i   (raw[gi]),
      .filt_o  (filt[gi]),
      .rise_o  (rise[gi])
    );
  end

  // Switch edges are not events; only their levels matter.
  assign unused_rise = rise[IDX_RUN] ^ rise[IDX_DATA];

  logic   rise_load;
  logic   rise_clr;
  state_e state_q;
  logic   set_q;
  logic   clear_q;
  logic   d_q;
  logic   oe_q;
  logic   pend_load_q;
  logic   pend_clr_q;

  assign rise_load = rise[IDX_LOAD];
  assign rise_clr  = rise[IDX_CLEAR];

  // Outputs are loaded with the value that belongs to the next state, so
  // every strobe lines up exactly with the state it is issued from.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      set_q       <= 1'b0;
      clear_q     <= 1'b0;
      d_q         <= 1'b0;
      oe_q        <= 1'b1;
      pend_load_q <= 1'b0;
      pend_clr_q  <= 1'b0;
    end else begin
      set_q   <= 1'b0;
      clear_q <= 1'b0;
      oe_q    <= 1'b1;
      case (state_q)
        IDLE: begin
          if (rise_load || pend_load_q) begin
            state_q     <= LOAD;
            set_q       <= 1'b1;
            d_q         <= filt[IDX_DATA];
            pend_load_q <= 1'b0;
            pend_clr_q  <= pend_clr_q | rise_clr;
          end else if (rise_clr || pend_clr_q) begin
            state_q    <= CLR;
            clear_q    <= 1'b1;
            pend_clr_q <= 1'b0;
          end else begin
            oe_q <= ~filt[IDX_RUN];
          end
        end
        LOAD: begin
          pend_load_q <= pend_load_q | rise_load;
          // A clear rising now is a new request, kept for after GAP.
          pend_clr_q  <= rise_clr;
          if (pend_clr_q) begin
            state_q <= CLR;
            clear_q <= 1'b1;
          end else begin
            state_q <= GAP;
          end
        end
        CLR: begin
          state_q     <= GAP;
          pend_load_q <= pend_load_q | rise_load;
          pend_clr_q  <= pend_clr_q | rise_clr;
        end
        default: begin
          state_q     <= IDLE;
          oe_q        <= ~filt[IDX_RUN];
          pend_load_q <= pend_load_q | rise_load;
          pend_clr_q  <= pend_clr_q | rise_clr;
        end
      endcase
    end
  end

  assign bus.Set   = set_q;
  assign bus.Clear = clear_q;
  assign bus.D     = d_q;
  assign bus.OE    = oe_q;

endmodule

// File: tb/tb_gal_ctrl_seq.sv
// Directed bench for gal_ctrl_seq with a strobe scoreboard (DEBOUNCE_CYCLES=4).
module tb_gal_ctrl_seq;

  typedef struct {
    logic [1:0] kind;   // {Set, Clear}
    logic       d;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   n_set;
  int   n_clr;
  exp_t sb[$];

  gal_ctrl_seq_if bus ();

  gal_ctrl_seq #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic d, input int at);
    exp_t e;
    e.kind = kind;
    e.d    = d;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Every strobe the DUT produces must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (bus.Set || bus.Clear)) begin
      if (bus.Set) n_set++;
      if (bus.Clear) n_clr++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_strobe observed={Set,Clear}=%b%b cyc=%0d expected=none",
               bus.Set, bus.Clear, cyc);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk_int("strobe_cycle", cyc, e.cyc);
        checks++;
        assert ({bus.Set, bus.Clear} === e.kind) else begin
          errors++;
          $error("FAIL strobe_kind observed=%b expected=%b cyc=%0d",
                 {bus.Set, bus.Clear}, e.kind, cyc);
        end
        if (e.kind == 2'b10) chk("load_d", bus.D, e.d);
      end
    end
  end

  initial begin
    int c;
    checks = 0;
    errors = 0;
    n_set  = 0;
    n_clr  = 0;
    rst_n  = 1'b0;
    bus.LoadBtn  = 1'b0;
    bus.ClearBtn = 1'b0;
    bus.RunSw    = 1'b0;
    bus.DataSw   = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_set", bus.Set, 1'b0);
    chk("rst_clear", bus.Clear, 1'b0);
    chk("rst_d", bus.D, 1'b0);
    chk("rst_oe", bus.OE, 1'b1);

    // Load latency with RunSw=1 so OE visibly goes high around the load.
    bus.RunSw  = 1'b1;
    bus.DataSw = 1'b1;
    tick(10);
    chk("run_oe_before_load", bus.OE, 1'b0);
    c = cyc;
    bus.LoadBtn = 1'b1;
    push(2'b10, 1'b1, c + 7);
    tick(6);
    chk("load_not_early", bus.Set, 1'b0);
    tick(1);
    chk("load_oe_in_load", bus.OE, 1'b1);
    tick(1);
    chk("load_set_dropped", bus.Set, 1'b0);
    chk("load_oe_in_gap", bus.OE, 1'b1);
    tick(1);
    chk("load_oe_after_gap", bus.OE, 1'b0);
    chk("load_d_held", bus.D, 1'b1);
    bus.LoadBtn = 1'b0;
    tick(10);

    // Run switch latency in both directions.
    c = cyc;
    bus.RunSw = 1'b0;
    tick(6);
    chk("run_off_early", bus.OE, 1'b0);
    tick(1);
    chk("run_off", bus.OE, 1'b1);
    bus.RunSw = 1'b1;
    tick(6);
    chk("run_on_early", bus.OE, 1'b1);
    tick(1);
    chk("run_on", bus.OE, 1'b0);
    bus.RunSw = 1'b0;
    tick(10);

    // Bounce: 3-cycle pulses never pass, a long press passes once.
    for (int i = 0; i < 5; i++) begin
      bus.ClearBtn = 1'b1;
      tick(3);
      bus.ClearBtn = 1'b0;
      tick(3);
    end
    tick(10);
    chk_int("bounce_no_clear", n_clr, 0);
    c = cyc;
    bus.ClearBtn = 1'b1;
    push(2'b01, 1'b0, c + 7);
    tick(12);
    bus.ClearBtn = 1'b0;
    tick(10);
    chk_int("bounce_one_clear", n_clr, 1);

    // Simultaneous load and clear with D=0.
    bus.DataSw = 1'b0;
    tick(10);
    c = cyc;
    bus.LoadBtn  = 1'b1;
    bus.ClearBtn = 1'b1;
    push(2'b10, 1'b0, c + 7);
    push(2'b01, 1'b0, c + 8);
    tick(9);
    chk("sim_gap_set", bus.Set, 1'b0);
    chk("sim_gap_clear", bus.Clear, 1'b0);
    chk("sim_gap_oe", bus.OE, 1'b1);
    tick(1);
    bus.LoadBtn  = 1'b0;
    bus.ClearBtn = 1'b0;
    tick(10);
    chk("sim_d_held", bus.D, 1'b0);

    // Back-to-back: clear's filtered rise lands in the GAP after a load.
    bus.DataSw = 1'b1;
    tick(10);
    c = cyc;
    bus.LoadBtn = 1'b1;
    push(2'b10, 1'b1, c + 7);
    push(2'b01, 1'b1, c + 10);
    tick(2);
    bus.ClearBtn = 1'b1;
    tick(7);
    chk("b2b_idle_clear", bus.Clear, 1'b0);
    chk("b2b_idle_set", bus.Set, 1'b0);
    tick(10);
    bus.LoadBtn  = 1'b0;
    bus.ClearBtn = 1'b0;
    tick(10);

    // Asynchronous reset in the middle of LOAD.
    c = cyc;
    bus.LoadBtn = 1'b1;
    push(2'b10, 1'b1, c + 7);
    tick(7);
    #2;
    rst_n = 1'b0;
    bus.LoadBtn = 1'b0;
    #1;
    chk("arst_set", bus.Set, 1'b0);
    chk("arst_clear", bus.Clear, 1'b0);
    chk("arst_d", bus.D, 1'b0);
    chk("arst_oe", bus.OE, 1'b1);
    tick(3);
    rst_n = 1'b1;
    tick(20);

    chk_int("total_set", n_set, 4);
    chk_int("total_clear", n_clr, 3);
    chk_int("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
